// File: rtl/riscv_load_ext_if.sv
// Load-extractor bus: request side (memory beat plus load decode) and the
// extended result side, each with its own valid/ready handshake.
interface riscv_load_ext_if #(
    parameter int XLEN      = 64,
    parameter int TAG_WIDTH = 5
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_rdata;
    logic [OFF_W-1:0]     in_offset;
    logic [2:0]           in_funct3;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_data;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_err;

    // Requester and result consumer
    modport master (
        output in_valid, in_rdata, in_offset, in_funct3, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    // Load extractor
    modport slave (
        input  in_valid, in_rdata, in_offset, in_funct3, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/riscv_load_ext.sv
// RISC-V load-data extractor/extender. Picks the addressed byte/half/word/
// double out of a memory beat, sign- or zero-extends it per funct3, flags
// illegal or misaligned loads, and registers the result behind a one-entry
// skid buffer so in_ready never depends combinationally on out_ready.
module riscv_load_ext #(
    parameter int XLEN             = 64,
    parameter int TAG_WIDTH        = 5,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    riscv_load_ext_if.slave bus
);
    localparam int OFF_W = $clog2(XLEN / 8);

    // Returns {err, data}; data is forced to zero whenever err is set.
    function automatic logic [XLEN:0] f_extract(
        input logic [XLEN-1:0]  rdata,
        input logic [OFF_W-1:0] off,
        input logic [2:0]       f3
    );
        logic [XLEN-1:0]  shifted;
        logic [XLEN-1:0]  upper;
        logic [7:0]       nbits;
        logic [OFF_W-1:0] amask;
        logic             sbit;
        logic             illegal;
        logic             misal;
        shifted = rdata >> {off, 3'b000};
        nbits   = 8'd8 << f3[1:0];
        // A shift by the full width leaves no upper bits for word/double.
        upper   = {XLEN{1'b1}} << nbits;
        case (f3[1:0])
            2'd0:    sbit = shifted[7];
            2'd1:    sbit = shifted[15];
            2'd2:    sbit = shifted[31];
            default: sbit = shifted[XLEN-1];
        endcase
        amask   = OFF_W'((4'd1 << f3[1:0]) - 4'd1);
        illegal = (f3 == 3'b111) ||
                  ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
        misal   = (ALLOW_MISALIGNED == 0) && (|(off & amask));
        if (illegal || misal) begin
            return {1'b1, {XLEN{1'b0}}};
        end
        return {1'b0, (shifted & ~upper) | ((sbit && !f3[2]) ? upper : {XLEN{1'b0}})};
    endfunction

    logic                 r_out_valid;
    logic [XLEN-1:0]      r_out_data;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_out_err;

    logic                 r_skid_valid;
    logic [XLEN-1:0]      r_skid_data;
    logic [TAG_WIDTH-1:0] r_skid_tag;
    logic                 r_skid_err;

    logic [XLEN:0]        w_result;
    logic                 w_in_fire;
    logic                 w_out_load;

    assign w_result   = f_extract(bus.in_rdata, bus.in_offset, bus.in_funct3);
    assign w_in_fire  = bus.in_valid && !r_skid_valid;
    assign w_out_load = !r_out_valid || bus.out_ready;

    // Output register: refill from skid first, else from the live input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_skid_data;
                r_out_tag   <= r_skid_tag;
                r_out_err   <= r_skid_err;
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result[XLEN-1:0];
                r_out_tag   <= bus.in_tag;
                r_out_err   <= w_result[XLEN];
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Skid occupancy: set when a request arrives into a stalled full output,
    // cleared when the output register takes the entry over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
            r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Skid payload: only meaningful while r_skid_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!w_out_load && w_in_fire) begin
            r_skid_data <= w_result[XLEN-1:0];
            r_skid_tag  <= bus.in_tag;
            r_skid_err  <= w_result[XLEN];
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_err   = r_out_err;
endmodule
